// File: rtl/alu_req_arbiter_pkg.sv
// Shared constants for the two-port ALU request arbiter: legal opcodes and FSM encodings.
package alu_req_arbiter_pkg;

  localparam logic [6:0] OP_ADD  = 7'd0;
  localparam logic [6:0] OP_SUB  = 7'd1;
  localparam logic [6:0] OP_XOR  = 7'd2;
  localparam logic [6:0] OP_OR   = 7'd3;
  localparam logic [6:0] OP_AND  = 7'd4;
  localparam int         NUM_OPS = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_req_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the requester that did not win last time wins a tie.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic update,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_grant;
  logic pick1;

  always_comb begin
    pick1 = req1 & (~req0 | ~last_grant);
    gnt1  = enable & pick1;
    gnt0  = enable & req0 & ~pick1;
  end

  // Reset to 1 so requester 0 wins the very first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= 1'b1;
    else if (update)
      last_grant <= gnt1;
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU between two requesters and returns tagged results on a valid/ready channel.
module alu_req_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OP_W    = 7,
  parameter int NUM_OPS = alu_req_arbiter_pkg::NUM_OPS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [OP_W-1:0]  alu_control,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_out,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic             busy
);

  import alu_req_arbiter_pkg::*;

  localparam logic [OP_W-1:0] OP_LIMIT = OP_W'(NUM_OPS);

  logic [1:0]       state;
  logic             err_q;
  logic             gnt0;
  logic             gnt1;
  logic             handshake;
  logic [OP_W-1:0]  sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state == ST_IDLE),
    .update (handshake),
    .req0   (req0_valid),
    .req1   (req1_valid),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  // A grant is only issued to a valid requester, so a grant is itself the handshake.
  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
    handshake  = gnt0 | gnt1;
    sel_op     = gnt1 ? req1_op : req0_op;
    sel_a      = gnt1 ? req1_a  : req0_a;
    sel_b      = gnt1 ? req1_b  : req0_b;
    resp_valid = (state == ST_RESP);
    busy       = (state != ST_IDLE);
  end

  // Unsupported opcodes still reach the ALU, but their result is replaced by zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      alu_control <= '0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      err_q       <= 1'b0;
      resp_id     <= 1'b0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            alu_control <= sel_op;
            alu_in1     <= sel_a;
            alu_in2     <= sel_b;
            resp_id     <= gnt1;
            err_q       <= (sel_op >= OP_LIMIT);
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_data <= err_q ? '0 : alu_out;
          resp_err  <= err_q;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: vector table of single operations plus hand-written multi-cycle sequences.
module tb_alu_req_arbiter;

  import alu_req_arbiter_pkg::*;

  typedef struct {
    logic        id;
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [6:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [6:0]  alu_control;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic        resp_valid, resp_ready, resp_id, resp_err, busy;
  logic [31:0] resp_data;

  int total = 0;
  int bad   = 0;
  vec_t vecs[9];

  alu_req_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .alu_control (alu_control),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_out     (alu_out),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared ALU; an unknown opcode yields a marker so forced zeros are visible.
  always_comb begin
    case (alu_control)
      OP_ADD:  alu_out = alu_in1 + alu_in2;
      OP_SUB:  alu_out = alu_in1 - alu_in2;
      OP_XOR:  alu_out = alu_in1 ^ alu_in2;
      OP_OR:   alu_out = alu_in1 | alu_in2;
      OP_AND:  alu_out = alu_in1 & alu_in2;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
  endtask

  // One isolated request; the payload is corrupted right after acceptance to prove it was sampled.
  task automatic applyStimulus(input vec_t v);
    resp_ready = 1'b1;
    if (v.id == 1'b0) begin
      req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
    end else begin
      req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
    end
    #1;
    checkOutput("vec_ready0", {31'd0, req0_ready}, {31'd0, v.id == 1'b0});
    checkOutput("vec_ready1", {31'd0, req1_ready}, {31'd0, v.id == 1'b1});
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~v.a; req1_a = ~v.a; req0_op = OP_XOR; req1_op = OP_XOR;
    #1;
    checkOutput("vec_exec_busy", {31'd0, busy}, 32'd1);
    checkOutput("vec_exec_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("vec_alu_control", {25'd0, alu_control}, {25'd0, v.op});
    step();
    checkOutput("vec_resp_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("vec_resp_id", {31'd0, resp_id}, {31'd0, v.id});
    checkOutput("vec_resp_data", resp_data, v.exp_data);
    checkOutput("vec_resp_err", {31'd0, resp_err}, {31'd0, v.exp_err});
    step();
    checkOutput("vec_back_idle", {31'd0, busy}, 32'd0);
    checkOutput("vec_idle_valid", {31'd0, resp_valid}, 32'd0);
    idleInputs();
  endtask

  initial begin
    vecs[0] = '{1'b0, OP_ADD, 32'd4,          32'd4,    32'd8,          1'b0};
    vecs[1] = '{1'b0, 7'd9,   32'd1,          32'd1,    32'd0,          1'b1};
    vecs[2] = '{1'b0, OP_AND, 32'h0000_00F0,  32'h3C,   32'h30,         1'b0};
    vecs[3] = '{1'b0, OP_ADD, 32'hFFFF_FFFF,  32'd1,    32'd0,          1'b0};
    vecs[4] = '{1'b1, OP_SUB, 32'd8,          32'd4,    32'd4,          1'b0};
    vecs[5] = '{1'b1, OP_XOR, 32'd8,          32'd4,    32'd12,         1'b0};
    vecs[6] = '{1'b1, OP_OR,  32'd8,          32'd4,    32'd12,         1'b0};
    vecs[7] = '{1'b0, OP_SUB, 32'd3,          32'd5,    32'hFFFF_FFFE,  1'b0};
    vecs[8] = '{1'b1, 7'd127, 32'd7,          32'd7,    32'd0,          1'b1};

    rst_n = 1'b0;
    resp_ready = 1'b1;
    idleInputs();
    step();
    step();
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_resp_data", resp_data, 32'd0);
    checkOutput("rst_alu_in1", alu_in1, 32'd0);
    checkOutput("rst_alu_control", {25'd0, alu_control}, 32'd0);
    rst_n = 1'b1;
    step();

    // Both requesters always valid: grants must alternate starting with requester 0.
    req0_valid = 1'b1; req0_op = OP_SUB; req0_a = 32'd8; req0_b = 32'd4;
    req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 32'd8; req1_b = 32'd4;
    for (int t = 0; t < 4; t++) begin
      #1;
      checkOutput("rr_ready0", {31'd0, req0_ready}, {31'd0, (t % 2) == 0});
      checkOutput("rr_ready1", {31'd0, req1_ready}, {31'd0, (t % 2) == 1});
      step();
      step();
      checkOutput("rr_resp_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("rr_resp_id", {31'd0, resp_id}, {31'd0, (t % 2) == 1});
      checkOutput("rr_resp_data", resp_data, ((t % 2) == 0) ? 32'd4 : 32'd12);
      step();
    end
    idleInputs();
    step();

    for (int i = 0; i < 9; i++)
      applyStimulus(vecs[i]);

    // Back-pressure: response must hold while the other requester is kept waiting.
    resp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = OP_OR; req1_a = 32'd8; req1_b = 32'd4;
    #1;
    checkOutput("bp_ready1", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd1; req0_b = 32'd1;
    step();
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("bp_resp_data", resp_data, 32'd12);
      checkOutput("bp_ready0", {31'd0, req0_ready}, 32'd0);
      step();
    end
    resp_ready = 1'b1;
    req0_valid = 1'b0;
    step();
    checkOutput("bp_release_busy", {31'd0, busy}, 32'd0);
    checkOutput("bp_release_valid", {31'd0, resp_valid}, 32'd0);
    idleInputs();

    // Reset asserted while a response is waiting: it must vanish and never reappear.
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd4; req0_b = 32'd4;
    step();
    req0_valid = 1'b0;
    step();
    checkOutput("mid_resp_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("mid_resp_data", resp_data, 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_data", resp_data, 32'd0);
    checkOutput("mid_rst_alu_in1", alu_in1, 32'd0);
    step();
    rst_n = 1'b1;
    req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 32'd9; req1_b = 32'd2;
    #1;
    checkOutput("post_rst_ready1", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    step();
    checkOutput("post_rst_resp_id", {31'd0, resp_id}, 32'd1);
    checkOutput("post_rst_resp_data", resp_data, 32'd7);
    resp_ready = 1'b1;
    step();
    checkOutput("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
